serial_adder: RTL and testbench

Bit-serial WIDTH-bit unsigned adder that processes one bit pair per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the sequential stage directly downstream of the one-bit half-adder cell: two half-adder cells form the full-adder slice, and this block drives that slice across a word. It is used wherever area matters more than latency. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_adder_full_adder_cell.sv | 43 ++++
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder assembled from two half-adder cells and an OR gate.
// This is the only arithmetic in the serial adder.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder_cell u_ha0 (
    .x (x),
    .y (y),
    .s (s1),
    .c (c1)
  );

  half_adder_cell u_ha1 (
    .x (s1),
    .y (cin),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder: one bit pair per clock, LSB first,
// through a single full-adder cell and a carry flip-flop. Result and carry
// are registered and announced by a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf (carry into MSB XOR carry out of MSB).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_shift;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;

  full_adder_cell u_fa (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_psum_w1
      assign psum_shift = fa_s;
    end else begin : g_psum_wn
      assign psum_shift = {fa_s, psum[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand shift, carry, bit counter and result capture; reset also clears
  // the previous result so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= (state_d == SHIFT);
      done <= (state_d == DONE);
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        psum  <= '0;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state_q == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        psum  <= psum_shift;
        carry <= fa_c;
        cnt   <= cnt + CNT_W'(1);
        if (last_bit) begin
          sum  <= psum_shift;
          cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB on this cycle
          ovf  <= carry ^ fa_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Expected results are
// computed by a behavioural model and queued when an operation is started.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t     r;
    logic [W:0] t;
    t   = {1'b0, x} + {1'b0, y};
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Present a one-cycle start; returns at the negedge after the accept edge.
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance negedge by negedge until done is seen or the budget runs out.
  task automatic wait_done(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0",
               busy, done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int   n;
    bit   ok;
    exp_t e;
    drive_start(8'h00, 8'h00);
    wait_done(40, n, ok);
    checks++;
    if (!ok || (n + 1) != 9) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles (seen=%0d) expected 9", n + 1, ok);
    end
    e = sb.pop_front();
    checks++;
    if ({cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL zero_result: got cout=%b sum=%h expected cout=%b sum=%h", cout, sum, e.c, e.s);
    end
  endtask

  task automatic test_carry();
    int   nb;
    exp_t e;
    drive_start(8'hFF, 8'h01);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL carry_busy_len: got %0d cycles expected 8", nb);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL carry_done_after_busy: got %b expected 1", done);
    end
    e = sb.pop_front();
    checks++;
    if ({cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL carry_result: got cout=%b sum=%h expected cout=%b sum=%h", cout, sum, e.c, e.s);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL carry_done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_ignore();
    int   n;
    bit   ok;
    exp_t e;
    drive_start(8'h5A, 8'h3C);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignore_done: got no done expected done");
    end
    e = sb.pop_front();
    checks++;
    if ({cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL ignore_result: got cout=%b sum=%h expected cout=%b sum=%h", cout, sum, e.c, e.s);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_second_op: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    int   n;
    bit   ok;
    bit   seen;
    exp_t e;
    drive_start(8'hF0, 8'h0F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL abort_cleared: got busy=%b done=%b cout=%b sum=%h expected all 0",
               busy, done, cout, sum);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse expected none");
    end
    drive_start(8'h0F, 8'h01);
    wait_done(40, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL abort_followup: got cout=%b sum=%h (seen=%0d) expected cout=%b sum=%h",
               cout, sum, ok, e.c, e.s);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    bit   ok;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h80;
    sb.push_back(model(8'h80, 8'h80));
    sb.push_back(model(8'h01, 8'h02));
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    wait_done(40, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL b2b_first: got cout=%b sum=%h (seen=%0d) expected cout=%b sum=%h",
               cout, sum, ok, e.c, e.s);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(40, n, ok);
    checks++;
    if (!ok || (n + 1) != 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles (seen=%0d) expected 9", n + 1, ok);
    end
    e = sb.pop_front();
    checks++;
    if ({cout, sum} !== {e.c, e.s}) begin
      errors++;
      $display("FAIL b2b_second: got cout=%b sum=%h expected cout=%b sum=%h", cout, sum, e.c, e.s);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int           n;
    bit           ok;
    exp_t         e;
    logic [W-1:0] xa [2];
    logic [W-1:0] xb [2];
    xa[0] = 8'h7F; xb[0] = 8'h01;
    xa[1] = 8'hFF; xb[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      drive_start(xa[k], xb[k]);
      wait_done(40, n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {ovf, cout, sum} !== {e.v, e.c, e.s}) begin
        errors++;
        $display("FAIL ovf_case%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                 k, ovf, cout, sum, e.v, e.c, e.s);
      end
    end
  endtask
`endif

  task automatic test_random();
    int   n;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      drive_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      wait_done(40, n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {cout, sum} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL random%0d: got cout=%b sum=%h (seen=%0d) expected cout=%b sum=%h",
                 k, cout, sum, ok, e.c, e.s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_ignore();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
